// File: rtl/return_stack_pkg.sv
// Shared defaults and sizing helper for the return-address stack.
package return_stack_pkg;

  localparam int RS_DATA_WIDTH = 16;
  localparam int RS_DEPTH      = 8;

  // count_o must represent 0..DEPTH inclusive, hence DEPTH+1 states
  function automatic int rs_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rstack_mem.sv
// DEPTH x DATA_WIDTH register file: one falling-edge write port, one asynchronous read port.
// Contents are intentionally never reset.
module rstack_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(negedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/return_stack.sv
// Return-address stack, falling-edge state, combinational top-of-stack for same-cycle PC load.
// Define RETURN_STACK_STATUS_EN to build sticky ovf_o/unf_o; otherwise they are tied low.
module return_stack
  import return_stack_pkg::*;
#(
  parameter  int DATA_WIDTH = RS_DATA_WIDTH,
  parameter  int DEPTH      = RS_DEPTH,
  localparam int CNT_W      = rs_cnt_width(DEPTH),
  localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_ni,
  input  logic                  pop_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  ovf_o,
  output logic                  unf_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [CNT_W-1:0]      w_top;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_waddr;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_push  = ~push_ni;
  assign w_pop   = ~pop_ni;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_top   = r_count - CNT_W'(1);

  always_comb begin
    w_count_nxt = r_count;
    w_we        = 1'b0;
    w_waddr     = r_count[ADDR_W-1:0];
    if (w_push && w_pop) begin
      // Simultaneous push/pop replaces the top; on empty it degrades to a plain push
      w_we = 1'b1;
      if (w_empty) begin
        w_waddr     = '0;
        w_count_nxt = CNT_W'(1);
      end else begin
        w_waddr = w_top[ADDR_W-1:0];
      end
    end else if (w_push && !w_full) begin
      w_we        = 1'b1;
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_empty) begin
      w_count_nxt = w_top;
    end
  end

  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  rstack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_we & ~reset_i),
    .waddr_i (w_waddr),
    .wdata_i (data_i),
    .raddr_i (w_top[ADDR_W-1:0]),
    .rdata_o (w_rdata)
  );

  assign data_o  = w_empty ? '0 : w_rdata;
  assign count_o = r_count;
  assign empty_o = w_empty;
  assign full_o  = w_full;

`ifdef RETURN_STACK_STATUS_EN
  logic r_ovf;
  logic r_unf;
  logic w_ovf_evt;
  logic w_unf_evt;

  assign w_ovf_evt = w_push & ~w_pop & w_full;
  assign w_unf_evt = w_pop & w_empty;

  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_evt) r_ovf <= 1'b1;
      if (w_unf_evt) r_unf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;
  assign unf_o = r_unf;
`else
  assign ovf_o = 1'b0;
  assign unf_o = 1'b0;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Table-driven bench for return_stack (DATA_WIDTH=16, DEPTH=4) with an expectation queue.
module tb_return_stack;

`ifdef RETURN_STACK_STATUS_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic        clk_i;
  logic        reset_i;
  logic        push_ni;
  logic        pop_ni;
  logic [15:0] data_i;
  logic [15:0] data_o;
  logic [2:0]  count_o;
  logic        empty_o;
  logic        full_o;
  logic        ovf_o;
  logic        unf_o;

  return_stack #(
    .DATA_WIDTH (16),
    .DEPTH      (4)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_ni (push_ni),
    .pop_ni  (pop_ni),
    .data_i  (data_i),
    .data_o  (data_o),
    .count_o (count_o),
    .empty_o (empty_o),
    .full_o  (full_o),
    .ovf_o   (ovf_o),
    .unf_o   (unf_o)
  );

  initial clk_i = 1'b1;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        push_n;
    logic        pop_n;
    logic [15:0] din;
    logic [2:0]  cnt;
    logic [15:0] dat;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vt [22];
  vec_t sb_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic pn, input logic qn, input logic [15:0] d,
                              input logic [2:0] c, input logic [15:0] q,
                              input logic f, input logic e, input logic o, input logic u);
    vec_t v;
    v.push_n = pn; v.pop_n = qn; v.din = d; v.cnt = c; v.dat = q;
    v.full = f; v.empty = e; v.ovf = o; v.unf = u;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    chk({tag, " count"}, 32'(count_o), 32'(e.cnt));
    chk({tag, " data"},  32'(data_o),  32'(e.dat));
    chk({tag, " full"},  32'(full_o),  32'(e.full));
    chk({tag, " empty"}, 32'(empty_o), 32'(e.empty));
    chk({tag, " ovf"},   32'(ovf_o),   32'(e.ovf));
    chk({tag, " unf"},   32'(unf_o),   32'(e.unf));
  endtask

  // Drive between edges, let one falling edge act, then compare off-edge
  task automatic apply(input int idx);
    vec_t e;
    push_ni = vt[idx].push_n;
    pop_ni  = vt[idx].pop_n;
    data_i  = vt[idx].din;
    sb_q.push_back(vt[idx]);
    @(negedge clk_i);
    #2;
    push_ni = 1'b1;
    pop_ni  = 1'b1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected entry for vector %0d", idx);
    end else begin
      e = sb_q.pop_front();
      check_outputs($sformatf("v%0d", idx), e);
    end
  endtask

  initial begin
    //            pn    qn    din     cnt   dat     full  empty ovf unf
    vt[0]  = mk(1'b0, 1'b1, 16'h0010, 3'd1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 1'b1, 16'h0020, 3'd2, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[2]  = mk(1'b1, 1'b0, 16'h0000, 3'd1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[3]  = mk(1'b1, 1'b0, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[4]  = mk(1'b1, 1'b0, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, SE);
    vt[5]  = mk(1'b0, 1'b1, 16'h0001, 3'd1, 16'h0001, 1'b0, 1'b0, 1'b0, SE);
    vt[6]  = mk(1'b0, 1'b1, 16'h0002, 3'd2, 16'h0002, 1'b0, 1'b0, 1'b0, SE);
    vt[7]  = mk(1'b0, 1'b1, 16'h0003, 3'd3, 16'h0003, 1'b0, 1'b0, 1'b0, SE);
    vt[8]  = mk(1'b0, 1'b1, 16'h0004, 3'd4, 16'h0004, 1'b1, 1'b0, 1'b0, SE);
    vt[9]  = mk(1'b0, 1'b1, 16'h0005, 3'd4, 16'h0004, 1'b1, 1'b0, SE,   SE);
    vt[10] = mk(1'b0, 1'b0, 16'h00AA, 3'd4, 16'h00AA, 1'b1, 1'b0, SE,   SE);
    vt[11] = mk(1'b1, 1'b1, 16'h1234, 3'd4, 16'h00AA, 1'b1, 1'b0, SE,   SE);
    vt[12] = mk(1'b1, 1'b0, 16'h0000, 3'd3, 16'h0003, 1'b0, 1'b0, SE,   SE);
    // after the asynchronous reset sequence
    vt[13] = mk(1'b0, 1'b1, 16'h0040, 3'd1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[14] = mk(1'b1, 1'b0, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[15] = mk(1'b0, 1'b0, 16'h0033, 3'd1, 16'h0033, 1'b0, 1'b0, 1'b0, SE);
    vt[16] = mk(1'b0, 1'b1, 16'h0044, 3'd2, 16'h0044, 1'b0, 1'b0, 1'b0, SE);
    vt[17] = mk(1'b0, 1'b0, 16'h0055, 3'd2, 16'h0055, 1'b0, 1'b0, 1'b0, SE);
    vt[18] = mk(1'b0, 1'b1, 16'h0066, 3'd3, 16'h0066, 1'b0, 1'b0, 1'b0, SE);
    vt[19] = mk(1'b0, 1'b1, 16'h0077, 3'd4, 16'h0077, 1'b1, 1'b0, 1'b0, SE);
    vt[20] = mk(1'b0, 1'b0, 16'h0088, 3'd4, 16'h0088, 1'b1, 1'b0, 1'b0, SE);
    vt[21] = mk(1'b1, 1'b0, 16'h0000, 3'd3, 16'h0066, 1'b0, 1'b0, 1'b0, SE);

    reset_i = 1'b1;
    push_ni = 1'b1;
    pop_ni  = 1'b1;
    data_i  = '0;
    repeat (2) @(negedge clk_i);
    #2;
    check_outputs("reset", mk(1'b1, 1'b1, 16'h0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    reset_i = 1'b0;

    for (int i = 0; i <= 12; i++) apply(i);

    // Reset between edges with count 3: outputs must clear without any clock edge
    #1;
    reset_i = 1'b1;
    #1;
    check_outputs("async_rst", mk(1'b1, 1'b1, 16'h0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    // A push held across an edge while in reset must be discarded
    push_ni = 1'b0;
    data_i  = 16'h0099;
    @(negedge clk_i);
    #2;
    chk("rst_push_count", 32'(count_o), 32'd0);
    chk("rst_push_data",  32'(data_o),  32'd0);
    push_ni = 1'b1;
    reset_i = 1'b0;

    for (int i = 13; i <= 21; i++) apply(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each stored return address.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries; legal values 2..256, power of two.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its falling edge.
REQ-004 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port push_ni, input, 1: push request, active low.
REQ-006 SHALL have port pop_ni, input, 1: pop request, active low.
REQ-007 SHALL have port data_i, input, DATA_WIDTH: address to push, normally program-counter-plus-word.
REQ-008 SHALL have port data_o, output, DATA_WIDTH: current top-of-stack, feeds the program counter load input.
REQ-009 SHALL have port count_o, output, $clog2(DEPTH+1): number of valid entries.
REQ-010 SHALL have ports empty_o and full_o, output, 1 each: count_o==0 and count_o==DEPTH respectively.
REQ-011 SHALL have ports ovf_o and unf_o, output, 1 each: overflow and underflow status.

Function
REQ-012 data_o SHALL combinationally present the top entry; it SHALL be 0 when empty_o is high.
REQ-013 Push only, not full: entry[count] <= data_i, count +1 at the falling edge; data_o shows data_i after that edge.
REQ-014 Pop only, not empty: count -1; data_o shows the previous entry after that edge; storage is not cleared.
REQ-015 Push when full (pop high): SHALL be ignored, contents and count unchanged, overflow event raised.
REQ-016 Pop when empty (push high): SHALL be ignored, count stays 0, underflow event raised.
REQ-017 Push and pop together, count>0: top entry SHALL be replaced by data_i, count unchanged, this includes the full case with no overflow.
REQ-018 Push and pop together, count==0: SHALL act as push only, count becomes 1, underflow event raised.
REQ-019 The pointer SHALL NOT wrap; count_o SHALL stay within 0..DEPTH at all times.
REQ-020 Read-to-load latency: a value popped at edge N SHALL be on data_o before edge N+1 so the program counter can load it at edge N+1.

Reset
REQ-021 reset_i high SHALL immediately force count_o=0, empty_o=1, full_o=0, data_o=0, ovf_o=0, unf_o=0, regardless of clk_i.
REQ-022 Storage array contents SHALL NOT be reset; reset asserted mid-push or mid-pop SHALL discard that operation.
REQ-023 Push or pop SHALL be honoured starting at the first falling edge after reset_i deasserts.

Configuration
REQ-024 Macro RETURN_STACK_STATUS_EN defined: ovf_o and unf_o SHALL be sticky, set by their events, and cleared only by reset_i.
REQ-025 Macro RETURN_STACK_STATUS_EN undefined: ovf_o and unf_o SHALL be tied 0, no sticky flops built, ports kept.

Structure
REQ-026 A shared package return_stack_pkg SHALL hold the DATA_WIDTH and DEPTH defaults and the count-width function.
REQ-027 Storage SHALL be a sub-module rstack_mem: DEPTH x DATA_WIDTH register file, one write port on the falling edge, one asynchronous read port.
REQ-028 Pointer/count and flag logic SHALL live in return_stack; no state machine beyond the counter is required.

Verification (DATA_WIDTH=16, DEPTH=4)
REQ-029 Reset, then push 0x0010,0x0020 -> count_o=2, data_o=0x0020; pop -> data_o=0x0010, count_o=1.
REQ-030 Push 0x1..0x4, then push 0x5 -> full_o=1, count_o=4, data_o=0x0004; ovf_o=1 with macro, 0 without.
REQ-031 From empty, pop -> count_o=0, data_o=0x0000; unf_o=1 with macro, 0 without.
REQ-032 Full with top 0x0004, push 0x00AA and pop together -> data_o=0x00AA, count_o=4, ovf_o unchanged.
REQ-033 Empty, push 0x0033 and pop together -> count_o=1, data_o=0x0033; unf_o=1 with macro.
REQ-034 Assert reset_i between edges with count_o=3 -> outputs zero at once with no clock edge; then push 0x0040 -> count_o=1, data_o=0x0040.
